// File: rtl/seg7_scan_decoder.sv
// Readback monitor for a multiplexed active-low seven-segment bus: debounces each
// digit strobe, decodes the pattern to BCD and publishes a full frame once every digit is captured.
module seg7_scan_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [6:0]            i_seg,
  input  logic [DIGITS-1:0]     i_an,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic [DIGITS-1:0]     o_digit_err,
  output logic                  o_valid
);

  localparam int              CNTW      = $clog2(STABLE_CYCLES);
  localparam logic [CNTW-1:0] CNT_CAP   = CNTW'(STABLE_CYCLES - 2);
  localparam logic [CNTW-1:0] CNT_MAX   = CNTW'(STABLE_CYCLES - 1);
  localparam logic [CNTW-1:0] CNT_ONE   = CNTW'(1'b1);
  localparam logic [DIGITS-1:0] ALL_SEEN = {DIGITS{1'b1}};
  localparam int              PAIRW     = DIGITS + 7;

  typedef enum logic [0:0] {
    TRACK = 1'b0,
    HELD  = 1'b1
  } state_t;

  // Returns {err, nibble}; blank maps to F without error, unknown patterns to E with error.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      7'h40:   res = 5'h00;
      7'h79:   res = 5'h01;
      7'h24:   res = 5'h02;
      7'h30:   res = 5'h03;
      7'h19:   res = 5'h04;
      7'h12:   res = 5'h05;
      7'h02:   res = 5'h06;
      7'h78:   res = 5'h07;
      7'h00:   res = 5'h08;
      7'h18:   res = 5'h09;
      7'h7F:   res = 5'h0F;
      default: res = 5'h1E;
    endcase
    return res;
  endfunction

  function automatic logic onehot_low(input logic [DIGITS-1:0] an);
    logic [DIGITS-1:0] sel;
    sel = ~an;
    return (sel != {DIGITS{1'b0}}) && ((sel & (sel - DIGITS'(1'b1))) == {DIGITS{1'b0}});
  endfunction

  logic [PAIRW-1:0]    sample_r;
  logic [PAIRW-1:0]    pair_s;
  logic                same_s;
  logic                legal_s;
  logic [4:0]          dec_s;
  logic                publish_s;

  state_t              state_r;
  state_t              state_s;
  logic [CNTW-1:0]     cnt_r;
  logic [CNTW-1:0]     cnt_s;
  logic                capture_s;

  logic [4*DIGITS-1:0] shadow_bcd_r;
  logic [4*DIGITS-1:0] shadow_bcd_s;
  logic [DIGITS-1:0]   shadow_err_r;
  logic [DIGITS-1:0]   shadow_err_s;
  logic [DIGITS-1:0]   seen_r;
  logic [DIGITS-1:0]   seen_s;

  // Classify the live bus sample against the one registered on the previous edge.
  always_comb begin
    pair_s    = {i_an, i_seg};
    same_s    = (pair_s == sample_r);
    legal_s   = onehot_low(i_an);
    dec_s     = seg_decode(i_seg);
    publish_s = (seen_r == ALL_SEEN);
  end

  // Debounce FSM: count identical legal samples, capture once, then wait for a change.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    capture_s = 1'b0;
    case (state_r)
      TRACK: begin
        if (legal_s && same_s) begin
          if (cnt_r == CNT_CAP) begin
            capture_s = 1'b1;
            cnt_s     = CNT_MAX;
            state_s   = HELD;
          end else if (cnt_r != CNT_MAX) begin
            cnt_s = cnt_r + CNT_ONE;
          end else begin
            cnt_s = cnt_r;
          end
        end else begin
          cnt_s   = {CNTW{1'b0}};
          state_s = TRACK;
        end
      end
      HELD: begin
        if (legal_s && same_s) begin
          cnt_s   = cnt_r;
          state_s = HELD;
        end else begin
          cnt_s   = {CNTW{1'b0}};
          state_s = TRACK;
        end
      end
      default: begin
        cnt_s   = {CNTW{1'b0}};
        state_s = TRACK;
      end
    endcase
  end

  // Shadow slot update on capture; the one-hot enable itself selects the slot.
  always_comb begin
    shadow_bcd_s = shadow_bcd_r;
    shadow_err_s = shadow_err_r;
    for (int k = 0; k < DIGITS; k++) begin
      if (capture_s && !i_an[k]) begin
        shadow_bcd_s[4*k +: 4] = dec_s[3:0];
        shadow_err_s[k]        = dec_s[4];
      end else begin
        shadow_bcd_s[4*k +: 4] = shadow_bcd_r[4*k +: 4];
        shadow_err_s[k]        = shadow_err_r[k];
      end
    end
  end

  // Seen mask clears on publish; captures never coincide with a publish cycle.
  always_comb begin
    if (publish_s) begin
      seen_s = {DIGITS{1'b0}};
    end else if (capture_s) begin
      seen_s = seen_r | ~i_an;
    end else begin
      seen_s = seen_r;
    end
  end

  // State, sample and shadow registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sample_r     <= {PAIRW{1'b1}};
      state_r      <= TRACK;
      cnt_r        <= {CNTW{1'b0}};
      shadow_bcd_r <= {(4*DIGITS){1'b1}};
      shadow_err_r <= {DIGITS{1'b0}};
      seen_r       <= {DIGITS{1'b0}};
    end else begin
      sample_r     <= pair_s;
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      shadow_bcd_r <= shadow_bcd_s;
      shadow_err_r <= shadow_err_s;
      seen_r       <= seen_s;
    end
  end

  // Registered outputs: load the whole frame and pulse valid for one cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_bcd       <= {(4*DIGITS){1'b1}};
      o_digit_err <= {DIGITS{1'b0}};
      o_valid     <= 1'b0;
    end else if (publish_s) begin
      o_bcd       <= shadow_bcd_r;
      o_digit_err <= shadow_err_r;
      o_valid     <= 1'b1;
    end else begin
      o_valid     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder (DIGITS=4, STABLE_CYCLES=4); inputs change on the
// falling edge, outputs are checked on the falling edge.
module tb_seg7_scan_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] bcd;
  logic [3:0]  derr;
  logic        valid;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int cyc       = 0;
  int valid_cnt = 0;
  int valid_cyc = -1;
  int v0;
  int n0;

  seg7_scan_decoder #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_seg       (seg),
    .i_an        (an),
    .o_bcd       (bcd),
    .o_digit_err (derr),
    .o_valid     (valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: counts cycles with o_valid high and remembers when the last one was.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      valid_cnt = valid_cnt + 1;
      valid_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
    @(negedge clk);
    an  = a;
    seg = s;
    repeat (n) @(posedge clk);
  endtask

  initial begin
    rst = 1'b1;
    an  = 4'($urandom);
    seg = 7'($urandom);

    // Reset with random bus activity
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_bcd", 32'(bcd), 32'h0000FFFF);
      check("rst_err", 32'(derr), 32'h0);
      check("rst_valid", 32'(valid), 32'h0);
      an  = 4'($urandom);
      seg = 7'($urandom);
    end
    rst = 1'b0;
    an  = 4'hF;
    seg = 7'h7F;

    // Normal frame with publish latency
    v0 = valid_cnt;
    hold(4'b1110, 7'h79, 8);
    hold(4'b1101, 7'h24, 8);
    hold(4'b1011, 7'h30, 8);
    @(negedge clk);
    an  = 4'b0111;
    seg = 7'h19;
    n0  = cyc + 1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("norm_pulses", 32'(valid_cnt - v0), 32'd1);
    check("norm_latency", 32'(valid_cyc), 32'(n0 + 4));
    check("norm_bcd", 32'(bcd), 32'h00004321);
    check("norm_err", 32'(derr), 32'h0);
    check("norm_valid_low", 32'(valid), 32'h0);

    // Glitch on digit 1 must not capture
    v0 = valid_cnt;
    hold(4'b1110, 7'h79, 8);
    hold(4'b1101, 7'h24, 3);
    hold(4'b1011, 7'h30, 8);
    hold(4'b0111, 7'h19, 8);
    @(negedge clk);
    check("glitch_no_pulse", 32'(valid_cnt - v0), 32'd0);
    hold(4'b1101, 7'h24, 8);
    @(negedge clk);
    check("glitch_pulse", 32'(valid_cnt - v0), 32'd1);
    check("glitch_bcd", 32'(bcd), 32'h00004321);

    // Illegal and blank segment patterns
    v0 = valid_cnt;
    hold(4'b1110, 7'h40, 8);
    hold(4'b1101, 7'h12, 8);
    hold(4'b1011, 7'h7E, 8);
    hold(4'b0111, 7'h7F, 8);
    @(negedge clk);
    check("pat_pulse", 32'(valid_cnt - v0), 32'd1);
    check("pat_bcd", 32'(bcd), 32'h0000FE50);
    check("pat_err", 32'(derr), 32'h4);

    // Multi-hot and zero-hot enables, then a frame split around a partial check
    v0 = valid_cnt;
    hold(4'b1100, 7'h40, 10);
    hold(4'b1111, 7'h40, 10);
    @(negedge clk);
    check("ill_no_pulse", 32'(valid_cnt - v0), 32'd0);
    hold(4'b1011, 7'h00, 8);
    hold(4'b0111, 7'h18, 8);
    @(negedge clk);
    check("ill_partial_no_pulse", 32'(valid_cnt - v0), 32'd0);
    check("ill_bcd_held", 32'(bcd), 32'h0000FE50);
    hold(4'b1110, 7'h02, 8);
    hold(4'b1101, 7'h78, 8);
    @(negedge clk);
    check("ill_pulse", 32'(valid_cnt - v0), 32'd1);
    check("ill_bcd", 32'(bcd), 32'h00009876);
    check("ill_err", 32'(derr), 32'h0);

    // Reset mid-frame discards partial captures
    v0 = valid_cnt;
    hold(4'b1110, 7'h79, 8);
    hold(4'b1101, 7'h24, 8);
    @(negedge clk);
    rst = 1'b1;
    an  = 4'b1011;
    seg = 7'h30;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_valid", 32'(valid), 32'h0);
    check("mid_rst_bcd", 32'(bcd), 32'h0000FFFF);
    rst = 1'b0;
    hold(4'b1011, 7'h30, 8);
    hold(4'b0111, 7'h19, 8);
    @(negedge clk);
    check("mid_no_pulse", 32'(valid_cnt - v0), 32'd0);
    hold(4'b1110, 7'h40, 8);
    hold(4'b1101, 7'h12, 8);
    @(negedge clk);
    check("mid_pulse", 32'(valid_cnt - v0), 32'd1);
    check("mid_bcd", 32'(bcd), 32'h00004350);
    check("mid_err", 32'(derr), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
